// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU-side types. Holds the RAM handshake state seen by
//               the memory arbiter, the machine word type and the arbiter FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // Machine word (addresses and data on the RAM port).
    typedef logic [31:0] word_t;

    // State reported by the RAM for the access currently presented to it.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Arbiter FSM: waiting for a request, or owning the RAM for one requester.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/ram_request_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request found when scanning upward from ptr, wrapping at NREQ.
// Ports       : req   in  NREQ  request vector
//               ptr   in  IDW   index with highest priority this cycle
//               valid out 1     at least one request is asserted
//               idx   out IDW   chosen requester (ptr when valid=0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;

    // Scan offsets from the far end back to zero so that the smallest offset
    // from ptr is the last hit and therefore wins. NREQ is a power of two, so
    // the IDW-bit add wraps modulo NREQ for free.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + IDW'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ram_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_request_arbiter
// Description : Shares one RAM port between NREQ cache requesters with
//               round-robin fairness and one transaction outstanding.
//               Optional macro RAM_ARB_PERF_EN adds saturating per-requester
//               grant and stall counters.
// Ports       : CLK, nRST              clock, async active-low reset
//               req_ren/req_wen        per-requester read/write request
//               req_addr/req_store     per-requester address / write data
//               req_wait               1 = hold request, 0 = done this cycle
//               req_load               RAM read data for the finishing requester
//               req_err                pulse with done when RAM reported ERROR
//               ramREN/ramWEN/ramaddr/ramstore  registered RAM controls
//               ramload/ramstate       RAM read data and handshake state
//               perf_grants/perf_stall (RAM_ARB_PERF_EN only) counters
// Revision    : 1.0 - initial release
// ============================================================================
module ram_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_ren,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0][31:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_store,
    output logic [NREQ-1:0]       req_wait,
    output word_t                 req_load,
    output logic [NREQ-1:0]       req_err,
    output logic                  ramREN,
    output logic                  ramWEN,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    input  word_t                 ramload,
    input  ramstate_t             ramstate
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [NREQ-1:0][15:0] perf_grants,
    output logic [NREQ-1:0][15:0] perf_stall
`endif
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t     state_q,    state_d;
    logic [IDW-1:0] grant_q,    grant_d;
    logic [IDW-1:0] ptr_q,      ptr_d;
    logic           ramREN_q,   ramREN_d;
    logic           ramWEN_q,   ramWEN_d;
    word_t          ramaddr_q,  ramaddr_d;
    word_t          ramstore_q, ramstore_d;

    logic [NREQ-1:0] req_any;
    logic [NREQ-1:0] done_vec;
    logic [NREQ-1:0] err_vec;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;

    assign req_any = req_ren | req_wen;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req_any),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        ramREN_d   = ramREN_q;
        ramWEN_d   = ramWEN_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        done_vec   = '0;
        err_vec    = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // Enables are loaded now so they reach RAM on the first
                    // GRANT cycle. A write wins over a simultaneous read.
                    grant_d    = pick_idx;
                    state_d    = GRANT;
                    ramWEN_d   = req_wen[pick_idx];
                    ramREN_d   = req_ren[pick_idx] & ~req_wen[pick_idx];
                    ramaddr_d  = req_addr[pick_idx];
                    ramstore_d = req_store[pick_idx];
                end else begin
                    ramREN_d = 1'b0;
                    ramWEN_d = 1'b0;
                end
            end
            GRANT: begin
                if (!req_any[grant_q]) begin
                    // Requester withdrew: release the RAM silently.
                    ramREN_d = 1'b0;
                    ramWEN_d = 1'b0;
                    ptr_d    = grant_q + IDW'(1);
                    state_d  = IDLE;
                end else if (ramstate == ACCESS || ramstate == ERROR) begin
                    done_vec[grant_q] = 1'b1;
                    err_vec[grant_q]  = (ramstate == ERROR);
                    ramREN_d = 1'b0;
                    ramWEN_d = 1'b0;
                    ptr_d    = grant_q + IDW'(1);
                    state_d  = IDLE;
                end else begin
                    // RAM outputs track the granted requester every cycle.
                    ramWEN_d   = req_wen[grant_q];
                    ramREN_d   = req_ren[grant_q] & ~req_wen[grant_q];
                    ramaddr_d  = req_addr[grant_q];
                    ramstore_d = req_store[grant_q];
                end
            end
            default: begin
                state_d  = IDLE;
                ramREN_d = 1'b0;
                ramWEN_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            ramREN_q   <= ramREN_d;
            ramWEN_q   <= ramWEN_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
        end
    end

    // done/err are combinational so the finishing requester sees req_wait=0,
    // its read data and any error in the same cycle RAM reports completion.
    assign req_wait = req_any & ~done_vec;
    assign req_err  = err_vec;
    assign req_load = ramload;
    assign ramREN   = ramREN_q;
    assign ramWEN   = ramWEN_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;

`ifdef RAM_ARB_PERF_EN
    logic [NREQ-1:0][15:0] perf_grants_q, perf_grants_d;
    logic [NREQ-1:0][15:0] perf_stall_q,  perf_stall_d;

    always_comb begin
        perf_grants_d = perf_grants_q;
        perf_stall_d  = perf_stall_q;
        for (int i = 0; i < NREQ; i++) begin
            if (done_vec[i] && perf_grants_q[i] != 16'hFFFF) begin
                perf_grants_d[i] = perf_grants_q[i] + 16'd1;
            end
            if (req_wait[i] && perf_stall_q[i] != 16'hFFFF) begin
                perf_stall_d[i] = perf_stall_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_grants_q <= perf_grants_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule : ram_request_arbiter
`default_nettype wire

// File: tb/tb_ram_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_request_arbiter
// Description : Directed self-checking bench for ram_request_arbiter (NREQ=4).
//               Inputs change 1 ns after the rising edge; outputs are checked
//               1 ns later, away from the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_request_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ = 4;

    logic                  CLK;
    logic                  nRST;
    logic [NREQ-1:0]       req_ren;
    logic [NREQ-1:0]       req_wen;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_store;
    logic [NREQ-1:0]       req_wait;
    word_t                 req_load;
    logic [NREQ-1:0]       req_err;
    logic                  ramREN;
    logic                  ramWEN;
    word_t                 ramaddr;
    word_t                 ramstore;
    word_t                 ramload;
    ramstate_t             ramstate;
`ifdef RAM_ARB_PERF_EN
    logic [NREQ-1:0][15:0] perf_grants;
    logic [NREQ-1:0][15:0] perf_stall;
`endif

    int n_cmp;
    int n_err;

    ram_request_arbiter #(
        .NREQ (NREQ)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .req_err   (req_err),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
`ifdef RAM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Round-robin grant order with all four requesters active from pointer 0.
    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [3:0] exp_wait;
        n_cmp     = 0;
        n_err     = 0;
        nRST      = 1'b0;
        req_ren   = '0;
        req_wen   = '0;
        req_store = '0;
        for (int i = 0; i < NREQ; i++) req_addr[i] = 32'h100 + i;
        ramload   = 32'h0;
        ramstate  = FREE;

        // ---------------- reset state ----------------
        tick();
        tick();
        #1;
        check("rst_ramREN",   {31'b0, ramREN}, 32'h0);
        check("rst_ramWEN",   {31'b0, ramWEN}, 32'h0);
        check("rst_ramaddr",  ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_req_err",  {28'b0, req_err}, 32'h0);
        tick();
        nRST = 1'b1;

        // ---------------- single read on requester 1 ----------------
        tick();                                   // cycle 0
        req_ren     = 4'b0010;
        req_addr[1] = 32'h40;
        #1;
        check("rd_c0_wait",   {28'b0, req_wait}, 32'h2);
        check("rd_c0_ramREN", {31'b0, ramREN}, 32'h0);
        tick();                                   // cycle 1
        ramstate = BUSY;
        #1;
        check("rd_c1_ramREN",  {31'b0, ramREN}, 32'h1);
        check("rd_c1_ramaddr", ramaddr, 32'h40);
        check("rd_c1_wait",    {28'b0, req_wait}, 32'h2);
        tick();                                   // cycle 2
        #1;
        check("rd_c2_ramREN", {31'b0, ramREN}, 32'h1);
        tick();                                   // cycle 3
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
        #1;
        check("rd_c3_wait", {28'b0, req_wait}, 32'h0);
        check("rd_c3_load", req_load, 32'hDEADBEEF);
        check("rd_c3_err",  {28'b0, req_err}, 32'h0);
        tick();                                   // cycle 4
        req_ren     = 4'b0000;
        req_addr[1] = 32'h101;
        ramstate    = FREE;
        #1;
        check("rd_c4_ramREN", {31'b0, ramREN}, 32'h0);

        // ---------------- round robin from pointer 0 ----------------
        tick();
        nRST = 1'b0;
        #1;
        nRST     = 1'b1;
        req_ren  = 4'b1111;                       // cycle 0
        ramstate = ACCESS;
        for (int c = 1; c <= 9; c++) begin
            tick();
            #1;
            if (c % 2 == 1) exp_wait = ~(4'b0001 << rr_order[(c - 1) / 2]);
            else            exp_wait = 4'b1111;
            check($sformatf("rr_c%0d_wait", c), {28'b0, req_wait}, {28'b0, exp_wait});
        end

        // ---------------- pointer wrap: ptr=3, requests on 0 and 2 ----------------
        tick();                                   // cycle 10: pointer 1, only req 2
        req_ren = 4'b0100;
        #1;
        check("wr_c10_wait", {28'b0, req_wait}, 32'h4);
        tick();                                   // cycle 11: req 2 done, ptr->3
        #1;
        check("wr_c11_wait", {28'b0, req_wait}, 32'h0);
        check("wr_c11_addr", ramaddr, 32'h102);
        tick();                                   // cycle 12
        req_ren = 4'b0101;
        #1;
        check("wr_c12_wait", {28'b0, req_wait}, 32'h5);
        tick();                                   // cycle 13: req 0 first
        #1;
        check("wr_c13_wait", {28'b0, req_wait}, 32'h4);
        check("wr_c13_addr", ramaddr, 32'h100);
        tick();                                   // cycle 14
        #1;
        check("wr_c14_wait", {28'b0, req_wait}, 32'h5);
        tick();                                   // cycle 15: then req 2
        #1;
        check("wr_c15_wait", {28'b0, req_wait}, 32'h1);
        check("wr_c15_addr", ramaddr, 32'h102);

        // ---------------- read+write together on requester 3 ----------------
        tick();                                   // cycle 16: ptr=3
        req_ren      = 4'b1000;
        req_wen      = 4'b1000;
        req_store[3] = 32'h1234;
        ramstate     = BUSY;
        tick();                                   // cycle 17
        #1;
        check("rw_ramWEN",   {31'b0, ramWEN}, 32'h1);
        check("rw_ramREN",   {31'b0, ramREN}, 32'h0);
        check("rw_ramstore", ramstore, 32'h1234);
        check("rw_ramaddr",  ramaddr, 32'h103);
        tick();                                   // cycle 18
        ramstate = ACCESS;
        #1;
        check("rw_done_wait", {28'b0, req_wait}, 32'h0);

        // ---------------- abort by requester 2 ----------------
        tick();                                   // cycle 19: ptr=0 -> picks 2
        req_ren  = 4'b0100;
        req_wen  = 4'b0000;
        ramstate = BUSY;
        #1;
        check("ab_c19_ramWEN", {31'b0, ramWEN}, 32'h0);
        tick();                                   // cycle 20: GRANT, requester leaves
        req_ren = 4'b0000;
        #1;
        check("ab_c20_ramREN", {31'b0, ramREN}, 32'h1);
        check("ab_c20_err",    {28'b0, req_err}, 32'h0);
        check("ab_c20_wait",   {28'b0, req_wait}, 32'h0);
        tick();                                   // cycle 21: IDLE, ptr=3
        req_ren = 4'b0010;
        #1;
        check("ab_c21_ramREN", {31'b0, ramREN}, 32'h0);

        // ---------------- RAM error on requester 1 ----------------
        tick();                                   // cycle 22
        ramstate = ERROR;
        #1;
        check("er_c22_ramREN", {31'b0, ramREN}, 32'h1);
        check("er_c22_err",    {28'b0, req_err}, 32'h2);
        check("er_c22_wait",   {28'b0, req_wait}, 32'h0);
        tick();                                   // cycle 23
        ramstate = BUSY;
        #1;
        check("er_c23_err",    {28'b0, req_err}, 32'h0);
        check("er_c23_wait",   {28'b0, req_wait}, 32'h2);
        check("er_c23_ramREN", {31'b0, ramREN}, 32'h0);

        // ---------------- reset in the middle of a GRANT ----------------
        tick();                                   // cycle 24
        #1;
        check("rs_grant_ramREN", {31'b0, ramREN}, 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        check("rs_async_ramREN", {31'b0, ramREN}, 32'h0);
        check("rs_async_ramWEN", {31'b0, ramWEN}, 32'h0);
        tick();
        nRST = 1'b1;
        #1;
        check("rs_rel_wait",   {28'b0, req_wait}, 32'h2);
        check("rs_rel_ramREN", {31'b0, ramREN}, 32'h0);
`ifdef RAM_ARB_PERF_EN
        check("rs_perf_grants_lo", perf_grants[31:0],  32'h0);
        check("rs_perf_grants_hi", perf_grants[63:32], 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_request_arbiter
`default_nettype wire
